// File: rtl/muldiv_unit.sv
// Purpose : iterative RV64M multiply/divide unit (radix-2 shift-add / restoring shift-subtract).
// Latency : 64 CALC cycles then a 1-cycle DONE pulse; div-by-zero and signed overflow go straight to DONE.
// Backpr. : accepts only in IDLE (ready_out); busy_out stalls the pipeline; no accept in DONE.
//
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   valid_in           request strobe; taken when aluControl_5[4] is set and the unit is idle
//   aluControl_5       10000 mul .. 10111 remu
//   a_64, b_64         rs1 / rs2 operands
//   flush_in           abort whatever is in flight; wins over a same-cycle request
//   ready_out          idle and able to accept
//   busy_out           iterations in flight
//   done_out           one-cycle completion pulse, result_64 valid in the same cycle
//   result_64          registered result, held until the next completion
module muldiv_unit #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_in,
  input  logic [4:0]      aluControl_5,
  input  logic [XLEN-1:0] a_64,
  input  logic [XLEN-1:0] b_64,
  input  logic            flush_in,
  output logic            ready_out,
  output logic            busy_out,
  output logic            done_out,
  output logic [XLEN-1:0] result_64
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic            neg_q, neg_d;
  // hi: product upper half / partial remainder
  // lo: multiplier shifting out + product lower half / dividend shifting out + quotient in
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  // opnd: multiplicand magnitude or divisor magnitude, constant during CALC
  logic [XLEN-1:0] opnd_q, opnd_d;
  logic [XLEN-1:0] result_q, result_d;

  // Bit 3 of the op code is always 0 for M-extension codes and carries no meaning here.
  logic unused_ctl;
  assign unused_ctl = aluControl_5[3];

  // ---------------------------------------------------------------------------
  // Accept-side decode: operand signs, magnitudes and special cases
  // ---------------------------------------------------------------------------
  logic [2:0]      op_in;
  logic            accept;
  logic            sgn_a, sgn_b, neg_a, neg_b, res_neg_in;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] special_res;

  always_comb begin
    op_in  = aluControl_5[2:0];
    accept = valid_in && aluControl_5[4] && (state_q == S_IDLE) && !flush_in;

    // mul/mulh: both signed; mulhsu: a only; mulhu: none; div/rem signed, divu/remu not.
    sgn_a = op_in[2] ? ~op_in[0] : (op_in[1:0] != 2'b11);
    sgn_b = op_in[2] ? ~op_in[0] : ~op_in[1];
    neg_a = sgn_a & a_64[XLEN-1];
    neg_b = sgn_b & b_64[XLEN-1];
    mag_a = neg_a ? -a_64 : a_64;
    mag_b = neg_b ? -b_64 : b_64;

    // Remainder takes the dividend's sign; product and quotient take the XOR.
    res_neg_in = (op_in[2] && op_in[1]) ? neg_a : (neg_a ^ neg_b);

    div_zero = op_in[2] && (b_64 == '0);
    div_ovf  = op_in[2] && !op_in[0] && (a_64 == SMIN) && (b_64 == '1);

    special_res = '0;
    if (div_zero) begin
      special_res = op_in[1] ? a_64 : '1;
    end else if (div_ovf) begin
      special_res = op_in[1] ? '0 : SMIN;
    end
  end

  // ---------------------------------------------------------------------------
  // Iteration datapath: a single (XLEN+1)-bit adder shared by both algorithms.
  // Multiply adds the multiplicand when the current multiplier bit is set.
  // Divide subtracts the divisor (x + ~y + 1) from the shifted partial remainder.
  // ---------------------------------------------------------------------------
  logic            is_div;
  logic [XLEN:0]   add_x, add_y, add_s;
  logic            borrow;
  logic [XLEN-1:0] hi_n, lo_n;

  always_comb begin
    is_div = op_q[2];
    add_x  = is_div ? {hi_q, lo_q[XLEN-1]} : {1'b0, hi_q};
    add_y  = is_div ? ~{1'b0, opnd_q} : (lo_q[0] ? {1'b0, opnd_q} : '0);
    add_s  = add_x + add_y + {{XLEN{1'b0}}, is_div};

    // Partial remainder stays below the divisor, so a non-negative difference
    // never reaches bit XLEN; bit XLEN set therefore means the subtract borrowed.
    borrow = add_s[XLEN];

    if (is_div) begin
      hi_n = borrow ? add_x[XLEN-1:0] : add_s[XLEN-1:0];
      lo_n = {lo_q[XLEN-2:0], ~borrow};
    end else begin
      hi_n = add_s[XLEN:1];
      lo_n = {add_s[0], lo_q[XLEN-1:1]};
    end
  end

  // ---------------------------------------------------------------------------
  // Final sign fixup on the values produced by the last iteration. One negator
  // at 2*XLEN serves everything: quotient/remainder are zero-extended, so the
  // low half of the negation is their XLEN-bit two's complement.
  // ---------------------------------------------------------------------------
  logic [2*XLEN-1:0] fin_mag, fin_sgn;
  logic [XLEN-1:0]   fin_res;

  always_comb begin
    if (is_div) begin
      fin_mag = {{XLEN{1'b0}}, (op_q[1] ? hi_n : lo_n)};
    end else begin
      fin_mag = {hi_n, lo_n};
    end
    fin_sgn = neg_q ? -fin_mag : fin_mag;
    // mul and all divide ops return the low half; mulh/mulhsu/mulhu the high half.
    if (is_div || (op_q[1:0] == 2'b00)) begin
      fin_res = fin_sgn[XLEN-1:0];
    end else begin
      fin_res = fin_sgn[2*XLEN-1:XLEN];
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM: next state and register updates
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;
    result_d = result_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d  = op_in;
          neg_d = res_neg_in;
          cnt_d = '0;
          if (div_zero || div_ovf) begin
            state_d  = S_DONE;
            result_d = special_res;
          end else begin
            state_d = S_CALC;
            hi_d    = '0;
            if (op_in[2]) begin
              lo_d   = mag_a;
              opnd_d = mag_b;
            end else begin
              lo_d   = mag_b;
              opnd_d = mag_a;
            end
          end
        end
      end
      S_CALC: begin
        hi_d  = hi_n;
        lo_d  = lo_n;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == {CW{1'b1}}) begin
          state_d  = S_DONE;
          result_d = fin_res;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort: drop the op without publishing anything.
    if (flush_in) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opnd_q   <= opnd_d;
      result_q <= result_d;
    end
  end

  assign ready_out = (state_q == S_IDLE);
  assign busy_out  = (state_q == S_CALC);
  assign done_out  = (state_q == S_DONE);
  assign result_64 = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Purpose : directed, table-driven check of muldiv_unit plus multi-cycle corner sequences.
// Latency : inputs driven and outputs sampled on the falling edge; accept happens on the next rising edge.
// Backpr. : each op waits for ready_out before presenting a request.
module tb_muldiv_unit;

  localparam logic [4:0] OP_MUL    = 5'b10000;
  localparam logic [4:0] OP_MULH   = 5'b10001;
  localparam logic [4:0] OP_MULHSU = 5'b10010;
  localparam logic [4:0] OP_MULHU  = 5'b10011;
  localparam logic [4:0] OP_DIV    = 5'b10100;
  localparam logic [4:0] OP_DIVU   = 5'b10101;
  localparam logic [4:0] OP_REM    = 5'b10110;
  localparam logic [4:0] OP_REMU   = 5'b10111;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] SMIN = 64'h8000_0000_0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in;
  logic [4:0]  alu_ctl;
  logic [63:0] a_in, b_in;
  logic        flush_in;
  logic        ready_out, busy_out, done_out;
  logic [63:0] result_64;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(64)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .valid_in     (valid_in),
    .aluControl_5 (alu_ctl),
    .a_64         (a_in),
    .b_64         (b_in),
    .flush_in     (flush_in),
    .ready_out    (ready_out),
    .busy_out     (busy_out),
    .done_out     (done_out),
    .result_64    (result_64)
  );

  typedef struct packed {
    logic [4:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    logic [7:0]  lat;   // cycles from accept edge to the done_out cycle
  } vec_t;

  vec_t vecs [18];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Returns on a falling edge with ready_out high (or after the bound expires).
  task automatic wait_ready(input string name);
    int k = 0;
    while (!ready_out && k < 200) begin
      k++;
      @(negedge clk);
    end
    if (!ready_out) check({name, "_ready_timeout"}, 64'(ready_out), 64'd1);
  endtask

  task automatic run_op(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp, input int lat, input string name);
    int   k;
    logic seen, viol, busy_seen;
    wait_ready(name);
    valid_in = 1'b1;
    alu_ctl  = op;
    a_in     = a;
    b_in     = b;
    @(negedge clk);            // accept edge has passed: this is cycle t
    valid_in  = 1'b0;
    alu_ctl   = 5'b0;
    k         = 0;
    seen      = 1'b0;
    viol      = 1'b0;
    busy_seen = 1'b0;
    while (!seen && k < 200) begin
      if (busy_out) busy_seen = 1'b1;
      if ((ready_out && busy_out) || (done_out && busy_out)) viol = 1'b1;
      if (done_out) seen = 1'b1;
      else begin
        k++;
        @(negedge clk);
      end
    end
    check({name, "_latency"}, 64'(seen ? k : 999), 64'(lat));
    check({name, "_result"}, result_64, exp);
    check({name, "_flag_overlap"}, 64'(viol), 64'd0);
    if (lat == 0) check({name, "_busy_seen"}, 64'(busy_seen), 64'd0);
  endtask

  initial begin
    int   k, k1, k2;
    logic seen, bad;

    vecs[0]  = '{OP_MUL,    64'd3,                    64'd5,  64'd15,                    8'd64};
    vecs[1]  = '{OP_MULH,   ONES,                     ONES,   64'd0,                     8'd64};
    vecs[2]  = '{OP_MULHU,  ONES,                     ONES,   64'hFFFF_FFFF_FFFF_FFFE,   8'd64};
    vecs[3]  = '{OP_MULHSU, ONES,                     ONES,   ONES,                      8'd64};
    vecs[4]  = '{OP_MUL,    SMIN,                     64'd2,  64'd0,                     8'd64};
    vecs[5]  = '{OP_DIV,    -64'sd7,                  64'd2,  -64'sd3,                   8'd64};
    vecs[6]  = '{OP_REM,    -64'sd7,                  64'd2,  -64'sd1,                   8'd64};
    vecs[7]  = '{OP_DIVU,   64'd100,                  64'd7,  64'd14,                    8'd64};
    vecs[8]  = '{OP_REMU,   64'd100,                  64'd7,  64'd2,                     8'd64};
    vecs[9]  = '{OP_DIV,    64'd5,                    64'd0,  ONES,                      8'd0};
    vecs[10] = '{OP_REMU,   64'd5,                    64'd0,  64'd5,                     8'd0};
    vecs[11] = '{OP_DIV,    SMIN,                     ONES,   SMIN,                      8'd0};
    vecs[12] = '{OP_REM,    SMIN,                     ONES,   64'd0,                     8'd0};
    vecs[13] = '{OP_MUL,    -64'sd3,                  64'd5,  -64'sd15,                  8'd64};
    // (-2^63)^2 = 2^126 -> high half 2^62
    vecs[14] = '{OP_MULH,   SMIN,                     SMIN,   64'h4000_0000_0000_0000,   8'd64};
    vecs[15] = '{OP_DIV,    64'd7,                    -64'sd2, -64'sd3,                  8'd64};
    vecs[16] = '{OP_REM,    64'd7,                    -64'sd2, 64'd1,                    8'd64};
    vecs[17] = '{OP_DIVU,   ONES,                     64'd1,  ONES,                      8'd64};

    rst_n    = 1'b0;
    valid_in = 1'b0;
    alu_ctl  = 5'b0;
    a_in     = '0;
    b_in     = '0;
    flush_in = 1'b0;

    // Reset state
    #2;
    check("rst_ready",  64'(ready_out), 64'd1);
    check("rst_busy",   64'(busy_out),  64'd0);
    check("rst_done",   64'(done_out),  64'd0);
    check("rst_result", result_64,      64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven vectors
    for (int i = 0; i < 18; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, int'(vecs[i].lat),
             $sformatf("vec%0d", i));
    end

    // Reset in the middle of a multiply (result_64 is nonzero beforehand)
    wait_ready("rstmid");
    valid_in = 1'b1; alu_ctl = OP_MUL; a_in = 64'd3; b_in = 64'd5;
    @(negedge clk);
    valid_in = 1'b0; alu_ctl = 5'b0;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rstmid_ready",  64'(ready_out), 64'd1);
    check("rstmid_busy",   64'(busy_out),  64'd0);
    check("rstmid_done",   64'(done_out),  64'd0);
    check("rstmid_result", result_64,      64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (done_out) seen = 1'b1;
    end
    check("rstmid_no_done", 64'(seen), 64'd0);
    run_op(OP_MUL, 64'd3, 64'd5, 64'd15, 64, "rstmid_redo");

    // Flush mid-divide: IDLE on the next cycle, no done, result held at 15
    wait_ready("flush");
    valid_in = 1'b1; alu_ctl = OP_DIVU; a_in = 64'd1000; b_in = 64'd3;
    @(negedge clk);            // cycle t
    valid_in = 1'b0; alu_ctl = 5'b0;
    repeat (10) @(negedge clk); // cycle t+10
    flush_in = 1'b1;
    @(negedge clk);            // cycle t+11
    flush_in = 1'b0;
    check("flush_ready", 64'(ready_out), 64'd1);
    check("flush_busy",  64'(busy_out),  64'd0);
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (done_out) seen = 1'b1;
      @(negedge clk);
    end
    check("flush_no_done", 64'(seen), 64'd0);
    check("flush_result",  result_64, 64'd15);

    // Non-M code is ignored
    valid_in = 1'b1; alu_ctl = 5'b00000; a_in = 64'd9; b_in = 64'd9;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (!ready_out || busy_out || done_out) bad = 1'b1;
    end
    valid_in = 1'b0;
    check("nonm_ignored", 64'(bad), 64'd0);
    check("nonm_result",  result_64, 64'd15);

    // Flush together with a valid request in IDLE: nothing accepted
    valid_in = 1'b1; alu_ctl = OP_MUL; a_in = 64'd2; b_in = 64'd2; flush_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0; alu_ctl = 5'b0; flush_in = 1'b0;
    check("flushvalid_state", {62'd0, ready_out, busy_out}, 64'b10);
    seen = 1'b0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (done_out || busy_out) seen = 1'b1;
    end
    check("flushvalid_idle", 64'(seen), 64'd0);

    // Back-to-back: valid_in held high; second op taken only in the first
    // ready cycle after DONE. First done at t+64, ready at t+65, second accept
    // on the following edge, so second done lands 66 cycles after the first
    // (65 cycles strictly between the two pulses).
    wait_ready("b2b");
    valid_in = 1'b1; alu_ctl = OP_MUL; a_in = 64'd6; b_in = 64'd7;
    @(negedge clk);            // cycle t
    a_in = 64'd11; b_in = 64'd13;
    k = 0; k1 = -1; k2 = -1;
    while (k2 < 0 && k < 300) begin
      if (done_out) begin
        if (k1 < 0) begin
          k1 = k;
          check("b2b_first_result", result_64, 64'd42);
        end else begin
          k2 = k;
          check("b2b_second_result", result_64, 64'd143);
        end
      end
      if (k1 >= 0 && k == k1 + 2) begin
        check("b2b_second_busy", 64'(busy_out), 64'd1);
        valid_in = 1'b0; alu_ctl = 5'b0;
      end
      if (k2 < 0) begin
        k++;
        @(negedge clk);
      end
    end
    valid_in = 1'b0;
    check("b2b_first_latency", 64'(k1), 64'd64);
    check("b2b_gap",           64'(k2 - k1), 64'd66);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
